// File: rtl/phrase_vram_writer.sv
// phrase_vram_writer: walks the NUM_CH x ROWS phrase table row-major, expands
// each 16-bit entry into eight ASCII cells ("C#5 45 2") and writes them to
// text VRAM as four packed 32-bit words over a stall-able write port.
// Optional feature macro: PHRASE_CURSOR_EN (cursor highlight via IV bits).
module phrase_vram_writer #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned ROWS       = 16,
  parameter int unsigned VRAM_AW    = 11,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned ROW_STRIDE = 40,
  parameter logic [3:0]  FGD_IDX    = 4'hF,
  parameter logic [3:0]  BKG_IDX    = 4'h0,
  localparam int unsigned PH_AW     = (NUM_CH * ROWS > 1) ? $clog2(NUM_CH * ROWS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [PH_AW-1:0]   ph_addr,
  output logic               ph_rd,
  input  logic [15:0]        ph_data,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [31:0]        vram_wdata,
  output logic               vram_we,
  input  logic               vram_ready
`ifdef PHRASE_CURSOR_EN
  ,
  input  logic [PH_AW-1:0]   cursor_ch,
  input  logic [PH_AW-1:0]   cursor_row,
  input  logic [1:0]         cursor_sel
`endif
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [6:0] CH_DASH  = 7'h2D;
  localparam logic [6:0] CH_SHARP = 7'h23;
  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_ZERO  = 7'h30;

  logic [2:0]       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [1:0]       k_q, k_d;
  logic             pend_q, pend_d;
  logic [7:0][6:0]  code_q, code_d;
  logic [7:0]       iv_q, iv_d;

  logic             last_row;
  logic             last_ch;
  logic             accept;
  logic [15:0]      cell_lo;
  logic [15:0]      cell_hi;

  // Expand one phrase entry into its eight display codes, left cell first:
  // letter, sharp, octave, ' ', vol tens, vol ones, ' ', instrument.
  function automatic logic [7:0][6:0] decode_entry(input logic [15:0] e);
    logic [7:0]      note;
    logic [5:0]      vol;
    logic [1:0]      inst;
    logic [3:0]      oct;
    logic [3:0]      idx;
    logic [2:0]      tens;
    logic [3:0]      ones;
    logic [6:0]      letter;
    logic [6:0]      sharp;
    logic [6:0]      octc;
    logic [7:0][6:0] r;
    note = e[15:8];
    vol  = e[7:2];
    inst = e[1:0];
    oct  = 4'(note / 8'd12);
    idx  = 4'(note % 8'd12);
    tens = 3'(vol / 6'd10);
    ones = 4'(vol % 6'd10);
    case (idx)
      4'd0, 4'd1:  letter = 7'h43;  // C
      4'd2, 4'd3:  letter = 7'h44;  // D
      4'd4:        letter = 7'h45;  // E
      4'd5, 4'd6:  letter = 7'h46;  // F
      4'd7, 4'd8:  letter = 7'h47;  // G
      4'd9, 4'd10: letter = 7'h41;  // A
      default:     letter = 7'h42;  // B
    endcase
    case (idx)
      4'd1, 4'd3, 4'd6, 4'd8, 4'd10: sharp = CH_SHARP;
      default:                       sharp = CH_DASH;
    endcase
    octc = CH_ZERO + {3'b000, oct};
    // Notes 108 and above mark an empty slot: blank the pitch cells only.
    if (note >= 8'd108) begin
      letter = CH_DASH;
      sharp  = CH_DASH;
      octc   = CH_DASH;
    end
    r[0] = letter;
    r[1] = sharp;
    r[2] = octc;
    r[3] = CH_SPACE;
    r[4] = CH_ZERO + {4'b0000, tens};
    r[5] = CH_ZERO + {3'b000, ones};
    r[6] = CH_SPACE;
    r[7] = CH_ZERO + {5'b00000, inst};
    return r;
  endfunction

  assign last_row = (row_q == ROW_W'(ROWS - 1));
  assign last_ch  = (ch_q == CH_W'(NUM_CH - 1));
  assign accept   = (state_q == S_EMIT) && vram_ready;

  // Next-state logic: scan sequencing, counter advance and restart bookkeeping.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ch_d    = ch_q;
    k_d     = k_q;
    pend_d  = pend_q;
    code_d  = code_q;
    iv_d    = iv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          row_d   = '0;
          ch_d    = '0;
          pend_d  = 1'b0;
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_EMIT;
        k_d     = '0;
        code_d  = decode_entry(ph_data);
        iv_d    = '0;
`ifdef PHRASE_CURSOR_EN
        if ((cursor_ch == PH_AW'(ch_q)) && (cursor_row == PH_AW'(row_q))) begin
          case (cursor_sel)
            2'b00:   iv_d = 8'b0000_0011;
            2'b01:   iv_d = 8'b0000_0100;
            2'b10:   iv_d = 8'b0011_0000;
            default: iv_d = 8'b1000_0000;
          endcase
        end
`endif
      end
      S_EMIT: begin
        if (accept) begin
          if (k_q == 2'd3) begin
            k_d = '0;
            if (last_ch) begin
              ch_d  = '0;
              row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
              ch_d = ch_q + 1'b1;
            end
            state_d = (last_row && last_ch) ? S_DONE : S_FETCH;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // A start seen during the scan, or arriving right now, chains a new
        // pass without passing through IDLE.
        if (pend_q || start) begin
          state_d = S_FETCH;
          row_d   = '0;
          ch_d    = '0;
          pend_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (start && (state_q != S_IDLE) && (state_q != S_DONE)) begin
      pend_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      ch_q    <= '0;
      k_q     <= '0;
      pend_q  <= 1'b0;
      code_q  <= '0;
      iv_q    <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      ch_q    <= ch_d;
      k_q     <= k_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
      iv_q    <= iv_d;
    end
  end

  // Word assembly: current k selects a cell pair; outputs are forced to zero
  // outside EMIT so the port is quiet (and zero right after reset).
  always_comb begin
    cell_lo    = {iv_q[{k_q, 1'b0}], code_q[{k_q, 1'b0}], FGD_IDX, BKG_IDX};
    cell_hi    = {iv_q[{k_q, 1'b1}], code_q[{k_q, 1'b1}], FGD_IDX, BKG_IDX};
    vram_we    = (state_q == S_EMIT);
    vram_wdata = '0;
    vram_addr  = '0;
    if (state_q == S_EMIT) begin
      vram_wdata = {cell_hi, cell_lo};
      vram_addr  = VRAM_AW'(BASE_ADDR + 32'(row_q) * ROW_STRIDE
                            + 32'(ch_q) * 32'd4 + 32'(k_q));
    end
  end

  // Status and phrase-read outputs decoded from the state register.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    ph_rd   = (state_q == S_FETCH);
    ph_addr = PH_AW'(32'(ch_q) * ROWS + 32'(row_q));
  end

endmodule
